gcd_operand_feeder: RTL and testbench

Upstream stage of the GCD datapath/controller pair. Buffers operand pairs arriving on a valid/ready interface in a small FIFO and launches one GCD job at a time:
- asserts `start`;
- serialises operand A then operand B onto the engine's shared `data_in` bus;
- waits for the engine's `done`, with a watchdog that abandons hung jobs.

An optional filter resolves zero operands locally, because the subtract-based engine never converges on them.

---
 rtl/gcd_operand_feeder.sv | 190 +++++++++++++++++++
 tb/tb_gcd_operand_feeder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_feeder.sv
// ---------------------------------------------------------------------------
// gcd_operand_feeder
//
// Upstream stage of the GCD engine. Operand pairs arriving on a valid/ready
// interface are queued in a small FIFO. One GCD job is launched at a time:
// `start` pulses for one cycle while `data_in` carries operand A, operand B
// follows on the next cycle, and the block then waits for the engine's
// `done`. A watchdog abandons jobs that never complete.
//
// Parameters
//   WIDTH    operand width, matches the engine data bus
//   DEPTH    FIFO depth in operand pairs (power of two, >= 2)
//   TIMEOUT  maximum cycles spent waiting for `done` (>= 4)
//
// Ports
//   clk         rising-edge clock shared with the engine
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair offered
//   in_ready    FIFO can accept (combinational, !full)
//   in_a, in_b  operands A and B
//   start       one-cycle launch pulse to the engine controller
//   data_in     registered engine load bus (A, then B)
//   done        engine completion level
//   busy        a job is being loaded or awaited
//   timeout     one-cycle pulse when a job is abandoned
//   byp_valid   one-cycle pulse: zero-operand result resolved locally
//   byp_result  local result, valid with byp_valid
//   count       FIFO occupancy
//
// Optional feature
//   GCD_FEED_ZERO_FILTER_EN  when defined, pairs with a zero operand are
//   resolved here (result a|b) instead of being sent to the subtract-based
//   engine, which never converges on them. When undefined, every pair is
//   launched and byp_valid/byp_result are tied to zero.
// ---------------------------------------------------------------------------
module gcd_operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       start,
  output logic [WIDTH-1:0]           data_in,
  input  logic                       done,
  output logic                       busy,
  output logic                       timeout,
  output logic                       byp_valid,
  output logic [WIDTH-1:0]           byp_result,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  // FIFO storage and bookkeeping
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;

  // Job control
  logic [1:0]         state;
  logic [WIDTH-1:0]   b_q;
  logic               armed;
  logic [WD_W-1:0]    wd_cnt;
  logic               zero_pair;
  logic               launch;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  // A full FIFO refuses a push even when the same edge pops an entry.
  assign push     = in_valid && !full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign {head_a, head_b} = mem[rd_ptr];

`ifdef GCD_FEED_ZERO_FILTER_EN
  assign zero_pair = (head_a == '0) || (head_b == '0);
`else
  assign zero_pair = 1'b0;
`endif

  assign launch = pop && !zero_pair;
  assign start  = (state == S_LOAD_A);
  assign busy   = (state != S_IDLE);

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are live, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // in the block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      data_in <= '0;
      b_q     <= '0;
      armed   <= 1'b0;
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            state   <= S_LOAD_A;
            data_in <= head_a;
            b_q     <= head_b;
          end
        end
        S_LOAD_A: begin
          state   <= S_LOAD_B;
          data_in <= b_q;
        end
        S_LOAD_B: begin
          state  <= S_WAIT;
          armed  <= 1'b0;
          wd_cnt <= '0;
        end
        S_WAIT: begin
          // `done` only counts once it has been seen low in this job, so a
          // level left high by the previous job cannot complete this one.
          // Completion is tested first so it wins over an expiring watchdog.
          if (armed && done) begin
            state <= S_IDLE;
          end else if (wd_cnt == WD_LAST) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (!done) armed <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GCD_FEED_ZERO_FILTER_EN
  // gcd(x,0) = x and gcd(0,0) = 0, so the result is simply a|b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid  <= 1'b0;
      byp_result <= '0;
    end else begin
      byp_valid <= pop && zero_pair;
      if (pop && zero_pair) byp_result <= head_a | head_b;
    end
  end
`else
  assign byp_valid  = 1'b0;
  assign byp_result = '0;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_gcd_operand_feeder
//
// Directed bench for gcd_operand_feeder. A job-timeline model (queue of
// pending pairs plus "cycles since launch" of the active job) predicts every
// output each cycle; a single compare process checks the DUT against it on
// the falling edge. Directed scenarios add hand-computed literal checks.
// Build with GCD_FEED_ZERO_FILTER_EN defined to exercise the zero filter.
// ---------------------------------------------------------------------------
module tb_gcd_operand_feeder;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          done = 1'b0;
  logic          in_ready;
  logic          start;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          timeout;
  logic          byp_valid;
  logic [W-1:0]  byp_result;
  logic [CW-1:0] count;

  gcd_operand_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .start      (start),
    .data_in    (data_in),
    .done       (done),
    .busy       (busy),
    .timeout    (timeout),
    .byp_valid  (byp_valid),
    .byp_result (byp_result),
    .count      (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2*W-1:0] q [$];       // pairs accepted but not yet popped
  bit             m_job;       // a job is being loaded or awaited
  int             m_t;         // cycles since the launch (0 = start cycle)
  bit             m_armed;     // done seen low during this job's wait
  logic [W-1:0]   m_a, m_b;
  bit             e_timeout;
  bit             e_byp;
  logic [W-1:0]   e_byp_res;

  task automatic model_step();
    bit             do_push;
    bit             is_zero;
    logic [2*W-1:0] p;
    if (!rst_n) begin
      q.delete();
      m_job = 0; m_t = 0; m_armed = 0;
      e_timeout = 0; e_byp = 0; e_byp_res = '0;
    end else begin
      do_push   = in_valid && (q.size() < D);
      e_timeout = 0;
      e_byp     = 0;
      if (m_job) begin
        if (m_t >= 2) begin
          if (m_armed && done)           m_job = 0;
          else if (m_t - 2 == TO - 1)    begin m_job = 0; e_timeout = 1; end
          else if (!done)                m_armed = 1;
        end
        m_t++;
      end else if (q.size() > 0) begin
        p = q.pop_front();
        is_zero = 0;
`ifdef GCD_FEED_ZERO_FILTER_EN
        is_zero = (p[2*W-1:W] == '0) || (p[W-1:0] == '0);
`endif
        if (is_zero) begin
          e_byp     = 1;
          e_byp_res = p[2*W-1:W] | p[W-1:0];
        end else begin
          m_job = 1; m_t = 0; m_armed = 0;
          m_a = p[2*W-1:W]; m_b = p[W-1:0];
        end
      end
      if (do_push) q.push_back({in_a, in_b});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- compare process and event log ----------------
  int           cyc = 0;
  int           n_to = 0;
  int           start_cyc [$];
  logic [W-1:0] start_dat [$];
  int           byp_cyc [$];
  logic [W-1:0] byp_val [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        check("in_ready", in_ready, q.size() < D);
        check("count", count, q.size());
        check("start", start, m_job && (m_t == 0));
        check("busy", busy, m_job);
        check("timeout", timeout, e_timeout);
        if (m_job) check("data_in", data_in, (m_t == 0) ? m_a : m_b);
`ifdef GCD_FEED_ZERO_FILTER_EN
        check("byp_valid", byp_valid, e_byp);
        if (e_byp) check("byp_result", byp_result, e_byp_res);
`else
        check("byp_valid_tied", byp_valid, 1'b0);
        check("byp_result_tied", byp_result, '0);
`endif
        if (start) begin start_cyc.push_back(cyc); start_dat.push_back(data_in); end
        if (timeout) n_to++;
        if (byp_valid) begin byp_cyc.push_back(cyc); byp_val.push_back(byp_result); end
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("push_accept_bound", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!start && n < 100);
    check("wait_start", start, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || count != '0) && n < budget) begin @(negedge clk); n++; end
    check("drain_busy", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, start, 1'b0);
    check({tag, "_data_in"}, data_in, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_byp_valid"}, byp_valid, 1'b0);
    check({tag, "_byp_result"}, byp_result, '0);
    check({tag, "_count"}, count, '0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int k;
    int to_before;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2 check_reset_values("por");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: single job (48,18), engine completes 10 cycles after launch
    push(16'd48, 16'd18);
    @(negedge clk);
    check("t1_start_latency", start, 1'b1);
    check("t1_data_a", data_in, 16'd48);
    @(negedge clk);
    check("t1_start_one_cycle", start, 1'b0);
    check("t1_data_b", data_in, 16'd18);
    repeat (10) @(negedge clk);
    check("t1_busy_in_wait", busy, 1'b1);
    done = 1'b1;
    @(negedge clk);
    check("t1_busy_after_done", busy, 1'b0);
    check("t1_count_after_done", count, '0);
    done = 1'b0;
    @(negedge clk);

    // 2: fill the FIFO behind a hung job
    to_before = n_to;
    push(16'd1, 16'd1);
    push(16'd2, 16'd2);
    push(16'd3, 16'd3);
    push(16'd4, 16'd4);
    push(16'd5, 16'd5);
    check("t2_count_full", count, 3'd4);
    check("t2_in_ready_full", in_ready, 1'b0);
    push(16'd6, 16'd6);
    check("t2_fifth_after_pop", n_to - to_before, 1);
    wait_idle(200);

    // 3: stale done held through launch, then a real low-high completion
    to_before = n_to;
    done = 1'b1;
    push(16'd12, 16'd8);
    wait_start();
    repeat (7) @(negedge clk);
    check("t3_no_early_done", busy, 1'b1);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    check("t3_completed", busy, 1'b0);
    check("t3_no_timeout", n_to - to_before, 0);
    done = 1'b0;
    @(negedge clk);

    // 4: watchdog expiry and the following launch
    push(16'd35, 16'd14);
    wait_start();
    push(16'd21, 16'd6);
    k = 1;
    while (!timeout && k < 60) begin @(negedge clk); k++; end
    check("t4_timeout_cycle", k, 18);
    @(negedge clk);
    check("t4_next_start", start, 1'b1);
    check("t4_next_data_a", data_in, 16'd21);
    check("t4_timeout_single", timeout, 1'b0);
    wait_idle(100);

    // 5: zero operands
    start_cyc.delete(); start_dat.delete(); byp_cyc.delete(); byp_val.delete();
    push(16'd0, 16'd7);
    push(16'd0, 16'd0);
    push(16'd9, 16'd3);
    wait_idle(150);
`ifdef GCD_FEED_ZERO_FILTER_EN
    check("t5_byp_events", byp_val.size(), 2);
    if (byp_val.size() == 2) begin
      check("t5_byp_first", byp_val[0], 16'd7);
      check("t5_byp_second", byp_val[1], 16'd0);
      check("t5_byp_consecutive", byp_cyc[1] - byp_cyc[0], 1);
    end
    check("t5_starts", start_dat.size(), 1);
    if (start_dat.size() == 1 && byp_cyc.size() == 2) begin
      check("t5_start_data", start_dat[0], 16'd9);
      check("t5_start_after_byp", start_cyc[0] - byp_cyc[1], 1);
    end
`else
    check("t5_byp_events", byp_val.size(), 0);
    check("t5_starts", start_dat.size(), 3);
    if (start_dat.size() == 3) begin
      check("t5_start0_data", start_dat[0], 16'd0);
      check("t5_start1_data", start_dat[1], 16'd0);
      check("t5_start2_data", start_dat[2], 16'd9);
    end
`endif
    @(negedge clk);

    // 6: reset in WAIT with two pairs queued
    push(16'd5, 16'd10);
    wait_start();
    push(16'd1, 16'd2);
    push(16'd3, 16'd4);
    check("t6_queued", count, 3'd2);
    check("t6_in_wait", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midjob_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    start_cyc.delete();
    repeat (30) @(negedge clk);
    check("t6_no_start_after_rst", start_cyc.size(), 0);
    check("t6_count_after_rst", count, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_time_limit: got time %0t required completion earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
